// File: rtl/am_pkg.sv
// Shared constants for the PCS-lane alignment-marker inserter: AM field layout,
// lane marker table, FSM state type and the AM block builder.
package am_pkg;

    localparam int AM_NB_BLOCK = 66;
    localparam int AM_NB_BIP   = 8;

    // Written as {d1,d0}: d0=1, d1=0 marks a control block
    localparam logic [1:0] AM_SYNC = 2'b01;

    localparam int AM_M0_LSB   = 2;
    localparam int AM_M1_LSB   = 10;
    localparam int AM_M2_LSB   = 18;
    localparam int AM_BIP3_LSB = 26;
    localparam int AM_M4_LSB   = 34;
    localparam int AM_M5_LSB   = 42;
    localparam int AM_M6_LSB   = 50;
    localparam int AM_BIP7_LSB = 58;

    localparam int AM_NUM_LANES = 20;

    // {M0,M1,M2} per PCS lane, M0 in the MSB
    localparam logic [23:0] AM_LANE_MARKERS [AM_NUM_LANES] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    typedef enum logic {
        FILL   = 1'b0,
        INSERT = 1'b1
    } am_state_e;

    function automatic logic [AM_NB_BLOCK-1:0] am_build(
        input logic [23:0]          marker,
        input logic [AM_NB_BIP-1:0] bip3,
        input logic [AM_NB_BIP-1:0] bip7
    );
        logic [AM_NB_BLOCK-1:0] blk;
        blk                       = '0;
        blk[1:0]                  = AM_SYNC;
        blk[AM_M0_LSB   +: 8]     = marker[23:16];
        blk[AM_M1_LSB   +: 8]     = marker[15:8];
        blk[AM_M2_LSB   +: 8]     = marker[7:0];
        blk[AM_BIP3_LSB +: 8]     = bip3;
        blk[AM_M4_LSB   +: 8]     = ~marker[23:16];
        blk[AM_M5_LSB   +: 8]     = ~marker[15:8];
        blk[AM_M6_LSB   +: 8]     = ~marker[7:0];
        blk[AM_BIP7_LSB +: 8]     = bip7;
        return blk;
    endfunction

endpackage

// File: rtl/am_bip8_acc.sv
// BIP-8 fold of one 66-bit block and the running parity accumulator
// (clear / load-with-fold / xor-with-fold), registered 8-bit output.
module am_bip8_acc
    import am_pkg::*;
#(
    parameter int NB_BLOCK = 66,
    parameter int NB_BIP   = 8
)(
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic                i_load,
    input  logic                i_xor_en,
    input  logic [NB_BLOCK-1:0] i_data,
    output logic [NB_BIP-1:0]   o_acc
);

    logic [NB_BIP-1:0] fold;
    logic [NB_BIP-1:0] acc_q;
    logic [NB_BIP-1:0] acc_d;

    genvar gi, gk;
    generate
        for (gi = 0; gi < NB_BIP; gi++) begin : g_fold
            logic [7:0] taps;
            for (gk = 0; gk < 8; gk++) begin : g_tap
                assign taps[gk] = i_data[2 + gi + 8*gk];
            end
            // Sync header bits fold into bits 3 and 4
            if (gi == 3) begin : g_sync0
                assign fold[gi] = (^taps) ^ i_data[0];
            end else if (gi == 4) begin : g_sync1
                assign fold[gi] = (^taps) ^ i_data[1];
            end else begin : g_plain
                assign fold[gi] = ^taps;
            end
        end
    endgenerate

    always_comb begin
        acc_d = acc_q;
        if (i_clear) begin
            acc_d = '0;
        end else if (i_load) begin
            acc_d = fold;
        end else if (i_xor_en) begin
            acc_d = acc_q ^ fold;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_acc = acc_q;

endmodule

// File: rtl/am_bip_inserter.sv
// Per-lane AM inserter: passes blocks through and emits one BIP-stamped AM every
// AM_PERIOD blocks. Define AM_BIP_ERR_INJECT_EN to add the one-shot BIP3 error injector.
module am_bip_inserter
    import am_pkg::*;
#(
    parameter int          NB_BLOCK    = 66,
    parameter int          NB_BIP      = 8,
    parameter int          AM_PERIOD   = 16384,
    parameter logic [23:0] LANE_MARKER = AM_LANE_MARKERS[0]
)(
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic [NB_BLOCK-1:0] i_data,
    output logic                o_ready,
    output logic                o_valid,
    output logic [NB_BLOCK-1:0] o_data,
    output logic                o_am_flag,
    output logic [NB_BIP-1:0]   o_last_bip
`ifdef AM_BIP_ERR_INJECT_EN
    ,
    input  logic                i_bip_err_inject
`endif
);

    localparam int               CNT_W    = $clog2(AM_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_PERIOD - 1);

    am_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [NB_BLOCK-1:0] data_q, data_d;
    logic                am_flag_q, am_flag_d;
    logic [NB_BIP-1:0]   last_bip_q, last_bip_d;

    logic                ready;
    logic                accept;
    logic                insert_go;
    logic [NB_BIP-1:0]   acc;
    logic [NB_BIP-1:0]   bip3_tx;
    logic [NB_BLOCK-1:0] am_tx;
    logic [NB_BLOCK-1:0] acc_data;

    assign ready     = i_enable && (state_q == FILL);
    assign accept    = ready && i_valid;
    assign insert_go = i_enable && (state_q == INSERT);

`ifdef AM_BIP_ERR_INJECT_EN
    logic inj_armed_q, inj_armed_d;

    // A pulse landing on the AM that consumes the armed shot is dropped
    always_comb begin
        inj_armed_d = inj_armed_q;
        if (insert_go) begin
            inj_armed_d = 1'b0;
        end
        if (i_bip_err_inject && !inj_armed_q) begin
            inj_armed_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            inj_armed_q <= 1'b0;
        end else begin
            inj_armed_q <= inj_armed_d;
        end
    end

    assign bip3_tx = acc ^ {{(NB_BIP-1){1'b0}}, inj_armed_q};
`else
    assign bip3_tx = acc;
`endif

    // BIP7 always carries the complement of the true parity
    assign am_tx    = am_build(LANE_MARKER, bip3_tx, ~acc);
    assign acc_data = (state_q == INSERT) ? am_tx : i_data;

    am_bip8_acc #(
        .NB_BLOCK (NB_BLOCK),
        .NB_BIP   (NB_BIP)
    ) u_acc (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (1'b0),
        .i_load   (insert_go),
        .i_xor_en (accept),
        .i_data   (acc_data),
        .o_acc    (acc)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        am_flag_d  = 1'b0;
        last_bip_d = last_bip_q;

        if (accept) begin
            valid_d = 1'b1;
            data_d  = i_data;
            if (cnt_q == CNT_LAST) begin
                state_d = INSERT;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // The AM itself occupies slot 0 of the period
        if (insert_go) begin
            valid_d    = 1'b1;
            data_d     = am_tx;
            am_flag_d  = 1'b1;
            last_bip_d = bip3_tx;
            state_d    = FILL;
            cnt_d      = CNT_W'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= INSERT;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            am_flag_q  <= 1'b0;
            last_bip_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            am_flag_q  <= am_flag_d;
            last_bip_q <= last_bip_d;
        end
    end

    assign o_ready    = ready;
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_am_flag  = am_flag_q;
    assign o_last_bip = last_bip_q;

endmodule

// File: doc/am_bip_inserter.md
# am_bip_inserter

Per-lane transmit block for the 100GbE PCS. It inserts one alignment marker (AM) every AM_PERIOD blocks into a 66-bit block stream. It also computes the BIP-8 over all blocks sent since the previous AM and writes that value into the BIP3 and BIP7 fields of each new AM. It sits after block distribution on each PCS lane and produces the BIP fields that the lane's receive-side error counter checks.

## Interface
- NB_BLOCK, 66: block width; bit 0 is the first bit transmitted.
- NB_BIP, 8: BIP width.
- AM_PERIOD, 16384: blocks per period, counting the AM; minimum 2.
- LANE_MARKER, 24'hC16821: M0,M1,M2 for this lane (M0 in the MSB).
- i_clock  in  1  clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  soft enable. When low, the block is frozen (see Operation).
- i_valid  in  1  input block valid.
- i_data  in  66  input block.
- o_ready  out  1  block can accept input this cycle.
- o_valid  out  1  output block valid.
- o_data  out  66  output block.
- o_am_flag  out  1  o_data holds an AM.
- o_last_bip  out  8  BIP3 of the most recent AM.

## Operation
- Two states:
  - FILL: pass-through. A block is accepted when i_valid, o_ready and i_enable are all high.
  - INSERT: o_ready is low and the AM is emitted.
- Block counter:
  - Width is $clog2(AM_PERIOD); it counts accepted blocks.
  - In FILL, when the counter equals AM_PERIOD-1 and a block is accepted: go to INSERT and clear the counter.
  - INSERT lasts exactly one cycle, then returns to FILL.
- The first state after reset is INSERT, so the first output block is an AM with BIP3=0x00 and BIP7=0xFF.
- AM layout:
  - Sync bits: d[0]=1, d[1]=0.
  - Fields: M0 d[9:2], M1 d[17:10], M2 d[25:18], BIP3 d[33:26], M4=~M0 d[41:34], M5=~M1 d[49:42], M6=~M2 d[57:50], BIP7=~BIP3 d[65:58].
- BIP fold of one block, per bit j:
  - bit0: d2^d10^…^d58
  - bit1: d3…d59
  - bit2: d4…d60
  - bit3: d0^d5^d13…d61
  - bit4: d1^d6^d14…d62
  - bit5: d7…d63
  - bit6: d8…d64
  - bit7: d9…d65
- Accumulator:
  - In FILL: acc ^= fold(block) for each accepted block.
  - In INSERT: BIP3 = acc, then acc is loaded with fold(emitted AM). The count therefore runs from and including the previous AM, excluding the current one.
  - fold(AM) = 0x08 for any marker.
- i_enable low:
  - o_ready=0, o_valid=0 on the next cycle.
  - Counter, accumulator and state hold.
  - A pending INSERT waits until i_enable returns high.
- Reset (asynchronous, including mid-period):
  - o_valid=0, o_data=0, o_am_flag=0, o_last_bip=0x00.
  - Counter=0, acc=0x00, state=INSERT.
  - o_ready=0 while reset is asserted.

## Timing
- Output is registered. A block accepted at edge n appears on o_data from edge n+1, with o_valid=1.
- o_ready is combinational from state and i_enable only, never from i_valid.
- In INSERT: o_ready=0 that cycle, the AM appears at the next edge with o_am_flag=1, and o_last_bip updates on that same edge.
- No accepted block in a cycle gives o_valid=0 the next cycle, and o_data holds its old value.
- Exactly one o_ready=0 cycle per AM_PERIOD-1 accepted blocks, independent of input gaps.

## Configuration
- AM_BIP_ERR_INJECT_EN defined:
  - Adds port i_bip_err_inject (in, 1).
  - A pulse arms a one-shot. The next AM is sent with BIP3 bit 0 inverted and BIP7 left as ~(true BIP3).
  - The accumulator folds the AM as actually transmitted.
  - The one-shot clears after use. Pulses while already armed are ignored.
- AM_BIP_ERR_INJECT_EN undefined: no port and no inject logic; AMs are always correct.

## Structure
- Package am_pkg holds:
  - AM sync constant 2'b01, written as {d1,d0}.
  - 20-entry lane marker table for lanes 0–19.
  - Field bit-offset localparams.
  - Two-value state enum, FILL and INSERT.
- One sub-module, am_bip8_acc: the fold and the accumulator, with clear, load and xor-enable controls, 8-bit registered output.

## Test plan
- Reset release with AM_PERIOD=4, lane 0 and i_valid held high:
  - First output is an AM: BIP3=0x00, BIP7=0xFF, M0..M2=C1,68,21.
  - Then 3 data blocks, then an AM; o_ready is low for 1 of every 4 cycles.
- Three all-zero data blocks (sync d1=1) between AMs → next AM BIP3=0x18, BIP7=0xE7; o_last_bip=0x18.
- i_valid low for 5 cycles after the 1st data block → AM still follows exactly the 3rd accepted block; o_valid=0 during the gap; BIP3=0x18.
- i_reset pulled low after 2 data blocks → o_valid=0 and o_data=0 immediately; after release, first output is an AM with BIP3=0x00.
- i_enable low for 3 cycles while INSERT is pending → no AM and o_ready=0 for those cycles; the AM follows the first enabled cycle, BIP unchanged.
- With AM_BIP_ERR_INJECT_EN, i_bip_err_inject pulsed during FILL → next AM BIP3=0x19, BIP7=0xE7; the following AM is correct again.
